// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
//   Helpers for the SECDED Hamming codeword layout, shared by the encoder
//   pipeline and the matching decoder.
//
//   Codeword layout (positions numbered from 0):
//     position 0        : overall parity (makes the whole codeword even weight)
//     position 2**k     : Hamming parity bit k
//     other positions   : data bits in ascending order (d0->3, d1->5, d2->6, ...)
//
//   hamming_p_w(data_w) : smallest p with 2**p >= data_w + p + 1
//   hamming_cw_w(data_w): total codeword width, data_w + p + 1
//   is_pow2(pos)        : 1 when pos is a parity-bit position (1, 2, 4, ...)
//   data_pos(idx)       : codeword position that carries data bit idx
// -----------------------------------------------------------------------------
package hamming_pkg;

   function automatic int hamming_p_w(input int data_w);
      int p;
      p = 0;
      // Walk downwards so the last hit is the smallest qualifying p.
      for (int i = 24; i >= 1; i--) begin
         if ((1 << i) >= data_w + i + 1) begin
            p = i;
         end
      end
      return p;
   endfunction

   function automatic int hamming_cw_w(input int data_w);
      return data_w + hamming_p_w(data_w) + 1;
   endfunction

   function automatic bit is_pow2(input int pos);
      return (pos > 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Data bit idx sits at the (idx)-th non-power-of-two position >= 3.
   // That position never exceeds 2*idx+4, which bounds the search.
   function automatic int data_pos(input int idx);
      int cnt;
      int pos;
      cnt = 0;
      pos = 0;
      for (int p = 1; p <= 2 * idx + 4; p++) begin
         if (!is_pow2(p) && (pos == 0)) begin
            if (cnt == idx) begin
               pos = p;
            end
            cnt = cnt + 1;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/hamming_parity_calc.sv
// -----------------------------------------------------------------------------
// hamming_parity_calc
//   Combinational Hamming parity word: XOR of the codeword positions of every
//   data bit that is 1. Bit k of the result is the parity bit stored at
//   position 2**k. Used by the encoder pipeline and by the SECDED decoder.
//
//   Ports
//     data    in   DATA_W  data word
//     parity  out  P_W     parity word (P_W derived from DATA_W)
// -----------------------------------------------------------------------------
module hamming_parity_calc
   import hamming_pkg::*;
#(
   parameter  int DATA_W = 11,
   localparam int P_W    = hamming_p_w(DATA_W)
) (
   input  logic [DATA_W-1:0] data,
   output logic [P_W-1:0]    parity
);

   // Each data bit contributes its own codeword position when set.
   logic [P_W-1:0] term [DATA_W];

   for (genvar i = 0; i < DATA_W; i++) begin : g_term
      localparam int POS = data_pos(i);
      assign term[i] = data[i] ? P_W'(POS) : '0;
   end

   always_comb begin
      parity = '0;
      for (int i = 0; i < DATA_W; i++) begin
         parity = parity ^ term[i];
      end
   end

endmodule

// File: rtl/hamming_secded_enc_pipe.sv
// -----------------------------------------------------------------------------
// hamming_secded_enc_pipe
//   Two-stage pipelined SECDED Hamming encoder with a valid/ready stream on
//   both sides and full backpressure.
//     stage 1: registers the data word and its Hamming parity word
//     stage 2: registers the assembled codeword including overall parity
//   Latency 2 cycles with out_ready high, one word per cycle throughput.
//
//   Parameters
//     DATA_W  data bits per word (>= 4)
//     CNT_W   width of the transferred-codeword counter
//     P_W     derived: Hamming parity bits
//     CW_W    derived: DATA_W + P_W + 1
//
//   Ports
//     clk        in   1       clock
//     rst        in   1       asynchronous active-high reset
//     in_valid   in   1       data word offered
//     in_ready   out  1       word accepted this cycle when in_valid is high
//     in_data    in   DATA_W  data word
//     out_valid  out  1       codeword present
//     out_ready  in   1       sink takes the codeword this cycle
//     out_cw     out  CW_W    codeword
//     cw_count   out  CNT_W   codewords transferred out (wraps)
//
//   Optional build macro HAMMING_ENC_ERRINJ_EN adds error injection:
//     inj_arm    in   1       pulse: latch inj_mask, set inj_busy
//     inj_mask   in   CW_W    bits to flip in the next word entering stage 2
//     inj_busy   out  1       injection pending/in flight; clears when the
//                             corrupted word leaves; arm while busy is ignored
// -----------------------------------------------------------------------------
module hamming_secded_enc_pipe
   import hamming_pkg::*;
#(
   parameter  int DATA_W = 11,
   parameter  int CNT_W  = 16,
   localparam int P_W    = hamming_p_w(DATA_W),
   localparam int CW_W   = DATA_W + P_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CW_W-1:0]   out_cw,
   output logic [CNT_W-1:0]  cw_count
`ifdef HAMMING_ENC_ERRINJ_EN
   ,
   input  logic              inj_arm,
   input  logic [CW_W-1:0]   inj_mask,
   output logic              inj_busy
`endif
);

   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;
   logic [P_W-1:0]    par_p1;
   logic              vld_p2;

   logic [P_W-1:0]    par_in;
   logic [CW_W-1:1]   body;
   logic              overall;
   logic [CW_W-1:0]   cw_next;
   logic [CW_W-1:0]   cw_load;
   logic              adv_p2;
   logic              out_fire;

   // Stage 2 may load whenever its slot is empty or is being emptied now;
   // stage 1 may load when it is empty or moving into stage 2.
   assign adv_p2    = !vld_p2 || out_ready;
   assign in_ready  = !vld_p1 || adv_p2;
   assign out_valid = vld_p2;
   assign out_fire  = vld_p2 && out_ready;

   hamming_parity_calc #(
      .DATA_W (DATA_W)
   ) u_parity (
      .data   (in_data),
      .parity (par_in)
   );

   // ---------------- stage 0 -> stage 1 boundary ----------------
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         data_p1 <= in_data;
         par_p1  <= par_in;
      end
   end

   // Codeword assembly from the stage 1 registers: data bits to their
   // non-power-of-two positions, parity bit k to position 2**k.
   for (genvar i = 0; i < DATA_W; i++) begin : g_dbit
      localparam int DPOS = data_pos(i);
      assign body[DPOS] = data_p1[i];
   end

   for (genvar k = 0; k < P_W; k++) begin : g_pbit
      localparam int PPOS = 1 << k;
      assign body[PPOS] = par_p1[k];
   end

   assign overall = ^body;
   assign cw_next = {body, overall};

`ifdef HAMMING_ENC_ERRINJ_EN
   logic [CW_W-1:0] inj_mask_q;
   logic            inj_applied;
   logic            inj_hit;

   // The first word loaded into stage 2 after arming takes the mask.
   assign inj_hit = inj_busy && !inj_applied;
   assign cw_load = inj_hit ? (cw_next ^ inj_mask_q) : cw_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inj_busy    <= 1'b0;
         inj_applied <= 1'b0;
         inj_mask_q  <= '0;
      end else if (!inj_busy) begin
         if (inj_arm) begin
            inj_busy    <= 1'b1;
            inj_applied <= 1'b0;
            inj_mask_q  <= inj_mask;
         end
      end else if (!inj_applied) begin
         if (adv_p2 && vld_p1) begin
            inj_applied <= 1'b1;
         end
      end else if (out_fire) begin
         // The corrupted word occupies stage 2 until this handshake.
         inj_busy    <= 1'b0;
         inj_applied <= 1'b0;
      end
   end
`else
   assign cw_load = cw_next;
`endif

   // ---------------- stage 1 -> stage 2 boundary ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         vld_p2   <= 1'b0;
         out_cw   <= '0;
         cw_count <= '0;
      end else begin
         if (in_ready) begin
            vld_p1 <= in_valid;
         end
         if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
               out_cw <= cw_load;
            end
         end
         if (out_fire) begin
            cw_count <= cw_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hamming_secded_enc_pipe.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for hamming_secded_enc_pipe. The main instance (DATA_W=11)
// carries the directed, backpressure, reset, exhaustive and injection phases;
// two further instances (DATA_W=26 and 57) take random streams at the end.
// Expected codewords come from a reference encoder that builds the codeword
// position by position and computes each check bit as the parity over the
// positions it covers.
// -----------------------------------------------------------------------------
module tb_hamming_secded_enc_pipe;

   typedef struct {
      logic [63:0] cw;
      logic [63:0] data;
      bit          clean;
   } qent_t;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [10:0] in_data;
   logic [15:0] out_cw, cw_count;

   logic        wv;
   logic [25:0] d26;
   logic [56:0] d57;
   logic        r26, v26, r57, v57;
   logic [31:0] cw26;
   logic [63:0] cw57;
   logic [15:0] n26, n57;

   int          n_vec = 0;
   int          n_err = 0;
   bit          rnd_rdy = 0;
   bit          rdy_val = 1;
   qent_t       q11[$];
   qent_t       q26[$];
   qent_t       q57[$];

`ifdef HAMMING_ENC_ERRINJ_EN
   logic        inj_arm;
   logic [15:0] inj_mask;
   logic        inj_busy, b26, b57;
`endif

   hamming_secded_enc_pipe #(.DATA_W(11), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_cw(out_cw), .cw_count(cw_count)
`ifdef HAMMING_ENC_ERRINJ_EN
      , .inj_arm(inj_arm), .inj_mask(inj_mask), .inj_busy(inj_busy)
`endif
   );

   hamming_secded_enc_pipe #(.DATA_W(26), .CNT_W(16)) dut26 (
      .clk(clk), .rst(rst), .in_valid(wv), .in_ready(r26),
      .in_data(d26), .out_valid(v26), .out_ready(1'b1),
      .out_cw(cw26), .cw_count(n26)
`ifdef HAMMING_ENC_ERRINJ_EN
      , .inj_arm(1'b0), .inj_mask(32'h0), .inj_busy(b26)
`endif
   );

   hamming_secded_enc_pipe #(.DATA_W(57), .CNT_W(16)) dut57 (
      .clk(clk), .rst(rst), .in_valid(wv), .in_ready(r57),
      .in_data(d57), .out_valid(v57), .out_ready(1'b1),
      .out_cw(cw57), .cw_count(n57)
`ifdef HAMMING_ENC_ERRINJ_EN
      , .inj_arm(1'b0), .inj_mask(64'h0), .inj_busy(b57)
`endif
   );

   // ---------------- reference model ----------------
   function automatic int cw_len(input int dw);
      int p;
      p = 0;
      while ((1 << p) < dw + p + 1) p++;
      return dw + p + 1;
   endfunction

   function automatic logic [63:0] model_enc(input logic [63:0] d, input int dw);
      logic [63:0] c;
      int          n;
      int          j;
      logic        b;
      n = cw_len(dw);
      c = '0;
      j = 0;
      for (int pos = 1; pos < n; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            c[pos] = d[j];
            j++;
         end
      end
      for (int k = 0; (1 << k) < n; k++) begin
         b = 1'b0;
         for (int pos = 1; pos < n; pos++) begin
            if (((pos >> k) & 1) == 1) b = b ^ c[pos];
         end
         c[1 << k] = b;
      end
      c[0] = ^c;
      return c;
   endfunction

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   // Compare against the expected codeword; for clean words also decode it:
   // zero syndrome, even weight and the original data recovered.
   task automatic chk_word(input string nm, input logic [63:0] got, input qent_t e, input int dw);
      int          n;
      int          j;
      logic [63:0] syn;
      logic [63:0] dd;
      check({nm, "_cw"}, got, e.cw);
      if (e.clean) begin
         n   = cw_len(dw);
         syn = '0;
         dd  = '0;
         j   = 0;
         for (int pos = 1; pos < n; pos++) begin
            if (got[pos]) syn = syn ^ 64'(pos);
            if ((pos & (pos - 1)) != 0) begin
               dd[j] = got[pos];
               j++;
            end
         end
         check({nm, "_syndrome"}, syn, 64'h0);
         check({nm, "_weight"}, {63'h0, ^got}, 64'h0);
         check({nm, "_decode"}, dd, e.data);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [10:0] d, input logic [63:0] exp, input bit clean);
      int    guard;
      qent_t e;
      guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      while (!in_ready && guard < 1000) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: in_ready stuck at 0, required 1");
      end else begin
         e.cw    = exp;
         e.data  = {53'h0, d};
         e.clean = clean;
         q11.push_back(e);
         @(posedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain11();
      int guard;
      guard = 0;
      while (q11.size() != 0 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (q11.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d words outstanding, required 0", q11.size());
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #5 rst = 1'b1;
      q11.delete();
      repeat (2) @(negedge clk);
      #5 rst = 1'b0;
   endtask

   // ---------------- out_ready driver ----------------
   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         out_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : rdy_val;
      end
   end

   // ---------------- monitor, DATA_W=11 ----------------
   initial begin : mon11
      bit          stall;
      logic [15:0] stall_cw;
      qent_t       e;
      stall = 0;
      stall_cw = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            stall = 0;
         end else begin
            if (stall) begin
               check("hold_valid", {63'h0, out_valid}, 64'h1);
               check("hold_cw", {48'h0, out_cw}, {48'h0, stall_cw});
            end
            if (out_valid && out_ready) begin
               if (q11.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_word: got %h, required no word", out_cw);
               end else begin
                  e = q11.pop_front();
                  chk_word("w11", {48'h0, out_cw}, e, 11);
               end
            end
            stall    = out_valid && !out_ready;
            stall_cw = out_cw;
         end
      end
   end

   // ---------------- monitor, DATA_W=26 and 57 ----------------
   initial begin : mon_wide
      qent_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (v26) begin
               if (q26.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_w26: got %h, required no word", cw26);
               end else begin
                  e = q26.pop_front();
                  chk_word("w26", {32'h0, cw26}, e, 26);
               end
            end
            if (v57) begin
               if (q57.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_w57: got %h, required no word", cw57);
               end else begin
                  e = q57.pop_front();
                  chk_word("w57", cw57, e, 57);
               end
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin : main_seq
      logic [63:0] r64;
      qent_t       e;
      int          guard;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      wv       = 1'b0;
      d26      = '0;
      d57      = '0;
`ifdef HAMMING_ENC_ERRINJ_EN
      inj_arm  = 1'b0;
      inj_mask = '0;
`endif
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", {63'h0, out_valid}, 64'h0);
      check("rst_out_cw", {48'h0, out_cw}, 64'h0);
      check("rst_cw_count", {48'h0, cw_count}, 64'h0);
      #4 rst = 1'b0;
      @(negedge clk);
      #3;
      check("rst_in_ready", {63'h0, in_ready}, 64'h1);

      // Latency: zero word with out_ready high appears two cycles later.
      send(11'h000, 64'h0000, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      check("lat_cycle1", {63'h0, out_valid}, 64'h0);
      @(negedge clk);
      #3;
      check("lat_cycle2", {63'h0, out_valid}, 64'h1);
      check("lat_cw", {48'h0, out_cw}, 64'h0);

      // Directed codewords, back to back.
      send(11'h001, 64'h000F, 1);
      send(11'h400, 64'h8117, 1);
      send(11'h7FF, 64'hFFFF, 1);
      idle();
      drain11();

      // Backpressure: 0..15 with out_ready toggling randomly.
      do_reset();
      rnd_rdy = 1;
      for (int i = 0; i < 16; i++) send(11'(i), model_enc(64'(i), 11), 1);
      idle();
      drain11();
      rnd_rdy = 0;
      rdy_val = 1;
      @(negedge clk);
      #3;
      check("bp_cw_count", {48'h0, cw_count}, 64'd16);

      // Reset with both stages full: nothing stale may come out afterwards.
      rdy_val = 0;
      @(negedge clk);
      send(11'h123, model_enc(64'h123, 11), 1);
      send(11'h456, model_enc(64'h456, 11), 1);
      idle();
      #1;
      check("full_out_valid", {63'h0, out_valid}, 64'h1);
      check("full_in_ready", {63'h0, in_ready}, 64'h0);
      #4 rst = 1'b1;
      #1;
      check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
      check("midrst_cw_count", {48'h0, cw_count}, 64'h0);
      q11.delete();
      rdy_val = 1;
      repeat (2) @(negedge clk);
      #5 rst = 1'b0;
      repeat (5) @(negedge clk);
      #3;
      check("postrst_out_valid", {63'h0, out_valid}, 64'h0);

      // Exhaustive 11-bit words under random backpressure.
      rnd_rdy = 1;
      for (int i = 0; i < 2048; i++) send(11'(i), model_enc(64'(i), 11), 1);
      idle();
      drain11();
      rnd_rdy = 0;
      @(negedge clk);
      #3;
      check("exh_cw_count", {48'h0, cw_count}, 64'd2048);

`ifdef HAMMING_ENC_ERRINJ_EN
      // Error injection: one corrupted word, the following one clean.
      @(negedge clk);
      inj_arm  = 1'b1;
      inj_mask = 16'h0008;
      @(negedge clk);
      inj_arm  = 1'b0;
      inj_mask = 16'h0000;
      #2;
      check("inj_busy_set", {63'h0, inj_busy}, 64'h1);
      send(11'h001, 64'h0007, 0);
      send(11'h001, 64'h000F, 1);
      idle();
      drain11();
      #3;
      check("inj_busy_clear", {63'h0, inj_busy}, 64'h0);
`endif

      // Wider instances with random data, out_ready tied high.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         r64 = {$urandom, $urandom};
         d26 = r64[25:0];
         r64 = {$urandom, $urandom};
         d57 = r64[56:0];
         wv  = 1'b1;
         #1;
         if (r26) begin
            e.cw = model_enc({38'h0, d26}, 26);
            e.data = {38'h0, d26};
            e.clean = 1;
            q26.push_back(e);
         end
         if (r57) begin
            e.cw = model_enc({7'h0, d57}, 57);
            e.data = {7'h0, d57};
            e.clean = 1;
            q57.push_back(e);
         end
      end
      @(negedge clk);
      wv = 1'b0;
      guard = 0;
      while ((q26.size() != 0 || q57.size() != 0) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("wide_drain", 64'(q26.size() + q57.size()), 64'h0);
      check("w26_count", {48'h0, n26}, 64'd300);
      check("w57_count", {48'h0, n57}, 64'd300);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
